// File: rtl/inst_enc_pkg.sv
//============================================================================
// Module   : inst_enc_pkg
// Brief    : Mnemonic codes, opcode/func constants and request-FIFO sizing
//            shared by the instruction encoder.
// Revision : 1.0
//============================================================================
`default_nettype none

package inst_enc_pkg;

    localparam int FIFO_DEPTH = 4;
    localparam int PTR_W      = $clog2(FIFO_DEPTH);
    localparam int CNT_W      = PTR_W + 1;
    localparam int ADDR_W     = 10;

    // Codes 28..31 are deliberately left unassigned (illegal).
    typedef enum logic [4:0] {
        MN_SLL     = 5'd0,
        MN_SRL     = 5'd1,
        MN_SRA     = 5'd2,
        MN_SLLV    = 5'd3,
        MN_JR      = 5'd4,
        MN_SYSCALL = 5'd5,
        MN_ADD     = 5'd6,
        MN_ADDU    = 5'd7,
        MN_SUB     = 5'd8,
        MN_AND     = 5'd9,
        MN_OR      = 5'd10,
        MN_NOR     = 5'd11,
        MN_SLT     = 5'd12,
        MN_SLTU    = 5'd13,
        MN_BEQ     = 5'd14,
        MN_BNE     = 5'd15,
        MN_BGTZ    = 5'd16,
        MN_ADDI    = 5'd17,
        MN_ADDIU   = 5'd18,
        MN_SLTI    = 5'd19,
        MN_SLTIU   = 5'd20,
        MN_ANDI    = 5'd21,
        MN_ORI     = 5'd22,
        MN_LW      = 5'd23,
        MN_SH      = 5'd24,
        MN_SW      = 5'd25,
        MN_J       = 5'd26,
        MN_JAL     = 5'd27
    } mnem_e;

    localparam logic [5:0] OP_RTYPE = 6'd0;
    localparam logic [5:0] OP_J     = 6'd2;
    localparam logic [5:0] OP_JAL   = 6'd3;
    localparam logic [5:0] OP_BEQ   = 6'd4;
    localparam logic [5:0] OP_BNE   = 6'd5;
    localparam logic [5:0] OP_BGTZ  = 6'd7;
    localparam logic [5:0] OP_ADDI  = 6'd8;
    localparam logic [5:0] OP_ADDIU = 6'd9;
    localparam logic [5:0] OP_SLTI  = 6'd10;
    localparam logic [5:0] OP_SLTIU = 6'd11;
    localparam logic [5:0] OP_ANDI  = 6'd12;
    localparam logic [5:0] OP_ORI   = 6'd13;
    localparam logic [5:0] OP_LW    = 6'd35;
    localparam logic [5:0] OP_SH    = 6'd41;
    localparam logic [5:0] OP_SW    = 6'd43;

    localparam logic [5:0] FN_SLL     = 6'd0;
    localparam logic [5:0] FN_SRL     = 6'd2;
    localparam logic [5:0] FN_SRA     = 6'd3;
    localparam logic [5:0] FN_SLLV    = 6'd4;
    localparam logic [5:0] FN_JR      = 6'd8;
    localparam logic [5:0] FN_SYSCALL = 6'd12;
    localparam logic [5:0] FN_ADD     = 6'd32;
    localparam logic [5:0] FN_ADDU    = 6'd33;
    localparam logic [5:0] FN_SUB     = 6'd34;
    localparam logic [5:0] FN_AND     = 6'd36;
    localparam logic [5:0] FN_OR      = 6'd37;
    localparam logic [5:0] FN_NOR     = 6'd39;
    localparam logic [5:0] FN_SLT     = 6'd42;
    localparam logic [5:0] FN_SLTU    = 6'd43;

    localparam logic [31:0] NOP_WORD = 32'h0000_0000;

    typedef struct packed {
        logic [4:0]  mnem;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [4:0]  shamt;
        logic [25:0] imm;
    } req_t;

    function automatic logic [31:0] r_word(input logic [4:0] rs, input logic [4:0] rt,
                                           input logic [4:0] rd, input logic [4:0] shamt,
                                           input logic [5:0] fn);
        return {OP_RTYPE, rs, rt, rd, shamt, fn};
    endfunction

    function automatic logic [31:0] i_word(input logic [5:0] op, input logic [4:0] rs,
                                           input logic [4:0] rt, input logic [15:0] imm16);
        return {op, rs, rt, imm16};
    endfunction

endpackage

`default_nettype wire

// File: rtl/inst_word_enc.sv
//============================================================================
// Module   : inst_word_enc
// Brief    : Combinational mnemonic + fields -> 32-bit MIPS word, with legal flag.
// Revision : 1.0
//============================================================================
`default_nettype none

module inst_word_enc
    import inst_enc_pkg::*;
(
    input  logic [4:0]  mnem,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    input  logic [4:0]  rd,
    input  logic [4:0]  shamt,
    input  logic [25:0] imm,
    output logic [31:0] word,
    output logic        legal
);

    mnem_e m;

    always_comb begin
        m     = mnem_e'(mnem);
        word  = NOP_WORD;
        legal = 1'b1;
        case (m)
            MN_SLL:     word = r_word(5'd0, rt, rd, shamt, FN_SLL);
            MN_SRL:     word = r_word(5'd0, rt, rd, shamt, FN_SRL);
            MN_SRA:     word = r_word(5'd0, rt, rd, shamt, FN_SRA);
            MN_SLLV:    word = r_word(rs, rt, rd, 5'd0, FN_SLLV);
            MN_JR:      word = r_word(rs, 5'd0, 5'd0, 5'd0, FN_JR);
            MN_SYSCALL: word = r_word(5'd0, 5'd0, 5'd0, 5'd0, FN_SYSCALL);
            MN_ADD:     word = r_word(rs, rt, rd, 5'd0, FN_ADD);
            MN_ADDU:    word = r_word(rs, rt, rd, 5'd0, FN_ADDU);
            MN_SUB:     word = r_word(rs, rt, rd, 5'd0, FN_SUB);
            MN_AND:     word = r_word(rs, rt, rd, 5'd0, FN_AND);
            MN_OR:      word = r_word(rs, rt, rd, 5'd0, FN_OR);
            MN_NOR:     word = r_word(rs, rt, rd, 5'd0, FN_NOR);
            MN_SLT:     word = r_word(rs, rt, rd, 5'd0, FN_SLT);
            MN_SLTU:    word = r_word(rs, rt, rd, 5'd0, FN_SLTU);
            MN_BEQ:     word = i_word(OP_BEQ, rs, rt, imm[15:0]);
            MN_BNE:     word = i_word(OP_BNE, rs, rt, imm[15:0]);
            MN_BGTZ:    word = i_word(OP_BGTZ, rs, 5'd0, imm[15:0]);
            MN_ADDI:    word = i_word(OP_ADDI, rs, rt, imm[15:0]);
            MN_ADDIU:   word = i_word(OP_ADDIU, rs, rt, imm[15:0]);
            MN_SLTI:    word = i_word(OP_SLTI, rs, rt, imm[15:0]);
            MN_SLTIU:   word = i_word(OP_SLTIU, rs, rt, imm[15:0]);
            MN_ANDI:    word = i_word(OP_ANDI, rs, rt, imm[15:0]);
            MN_ORI:     word = i_word(OP_ORI, rs, rt, imm[15:0]);
            MN_LW:      word = i_word(OP_LW, rs, rt, imm[15:0]);
            MN_SH:      word = i_word(OP_SH, rs, rt, imm[15:0]);
            MN_SW:      word = i_word(OP_SW, rs, rt, imm[15:0]);
            MN_J:       word = {OP_J, imm};
            MN_JAL:     word = {OP_JAL, imm};
            default:    legal = 1'b0;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/inst_encoder.sv
//============================================================================
// Module   : inst_encoder
// Brief    : Request FIFO + FSM streaming encoded words into instruction memory.
//            Optional macro INST_ENC_CHECK_EN: drop illegal codes and flag err.
// Revision : 1.0
//============================================================================
`default_nettype none

module inst_encoder
    import inst_enc_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        stop,
    input  logic [9:0]  base_addr,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [4:0]  in_mnem,
    input  logic [4:0]  in_rs,
    input  logic [4:0]  in_rt,
    input  logic [4:0]  in_rd,
    input  logic [4:0]  in_shamt,
    input  logic [25:0] in_imm,
    output logic        imem_we,
    output logic [9:0]  imem_addr,
    output logic [31:0] imem_wdata,
    output logic        busy,
    output logic        full,
    output logic [10:0] count
`ifdef INST_ENC_CHECK_EN
    ,
    output logic        err
`endif
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_FULL  = 2'd3;

    localparam logic [CNT_W-1:0] FIFO_FULL_LVL = CNT_W'(FIFO_DEPTH);

    logic [1:0]        state_q, state_d;
    logic [9:0]        addr_q, addr_d;
    logic [10:0]       count_q, count_d;
    logic              full_q, full_d;
    logic              imem_we_q, imem_we_d;
    logic [9:0]        imem_addr_q, imem_addr_d;
    logic [31:0]       imem_wdata_q, imem_wdata_d;
    req_t              fifo_mem_q [FIFO_DEPTH];
    req_t              fifo_mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  fifo_cnt_q, fifo_cnt_d;
`ifdef INST_ENC_CHECK_EN
    logic              err_q, err_d;
`endif

    logic              push;
    logic              pop;
    logic              flush;
    req_t              in_req;
    req_t              head;
    logic [31:0]       enc_word;
    logic              enc_legal;

    assign in_ready = (state_q == ST_RUN) && (fifo_cnt_q != FIFO_FULL_LVL);
    assign push     = in_valid && in_ready;
    assign pop      = (fifo_cnt_q != '0) && ((state_q == ST_RUN) || (state_q == ST_DRAIN));
    assign head     = fifo_mem_q[rd_ptr_q];

    always_comb begin
        in_req.mnem  = in_mnem;
        in_req.rs    = in_rs;
        in_req.rt    = in_rt;
        in_req.rd    = in_rd;
        in_req.shamt = in_shamt;
        in_req.imm   = in_imm;
    end

    inst_word_enc u_word_enc (
        .mnem  (head.mnem),
        .rs    (head.rs),
        .rt    (head.rt),
        .rd    (head.rd),
        .shamt (head.shamt),
        .imm   (head.imm),
        .word  (enc_word),
        .legal (enc_legal)
    );

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        count_d      = count_q;
        full_d       = full_q;
        imem_we_d    = 1'b0;
        imem_addr_d  = imem_addr_q;
        imem_wdata_d = imem_wdata_q;
        fifo_mem_d   = fifo_mem_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        flush        = 1'b0;
`ifdef INST_ENC_CHECK_EN
        err_d        = err_q;
`endif

        if (push) begin
            fifo_mem_d[wr_ptr_q] = in_req;
            wr_ptr_d             = wr_ptr_q + 1'b1;
        end

        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
`ifdef INST_ENC_CHECK_EN
            if (!enc_legal) begin
                err_d = 1'b1;
            end else
`endif
            begin
                imem_we_d    = 1'b1;
                imem_addr_d  = addr_q;
                imem_wdata_d = enc_legal ? enc_word : NOP_WORD;
                count_d      = count_q + 11'd1;
                // The last address is terminal: latch full and discard the rest.
                if (addr_q == '1) begin
                    full_d = 1'b1;
                    flush  = 1'b1;
                end else begin
                    addr_d = addr_q + 10'd1;
                end
            end
        end

        fifo_cnt_d = fifo_cnt_q + CNT_W'(push) - CNT_W'(pop);
        if (flush) begin
            fifo_cnt_d = '0;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
        end

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_RUN;
                    addr_d  = base_addr;
                    count_d = '0;
                    full_d  = 1'b0;
`ifdef INST_ENC_CHECK_EN
                    err_d   = 1'b0;
`endif
                end
            end
            ST_RUN: begin
                if (flush)     state_d = ST_FULL;
                else if (stop) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (flush)                 state_d = ST_FULL;
                else if (fifo_cnt_q == '0) state_d = ST_IDLE;
            end
            ST_FULL: begin
                if (stop) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            addr_q       <= '0;
            count_q      <= '0;
            full_q       <= 1'b0;
            imem_we_q    <= 1'b0;
            imem_addr_q  <= '0;
            imem_wdata_q <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            fifo_cnt_q   <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_mem_q[i] <= '0;
            end
`ifdef INST_ENC_CHECK_EN
            err_q        <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            count_q      <= count_d;
            full_q       <= full_d;
            imem_we_q    <= imem_we_d;
            imem_addr_q  <= imem_addr_d;
            imem_wdata_q <= imem_wdata_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            fifo_cnt_q   <= fifo_cnt_d;
            fifo_mem_q   <= fifo_mem_d;
`ifdef INST_ENC_CHECK_EN
            err_q        <= err_d;
`endif
        end
    end

    assign imem_we    = imem_we_q;
    assign imem_addr  = imem_addr_q;
    assign imem_wdata = imem_wdata_q;
    assign busy       = (state_q != ST_IDLE);
    assign full       = full_q;
    assign count      = count_q;
`ifdef INST_ENC_CHECK_EN
    assign err        = err_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_inst_encoder.sv
//============================================================================
// Module   : tb_inst_encoder
// Brief    : Scoreboard bench for inst_encoder (honours INST_ENC_CHECK_EN).
// Revision : 1.0
//============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_inst_encoder;
    import inst_enc_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic [9:0]  base_addr = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [4:0]  in_mnem = '0;
    logic [4:0]  in_rs = '0;
    logic [4:0]  in_rt = '0;
    logic [4:0]  in_rd = '0;
    logic [4:0]  in_shamt = '0;
    logic [25:0] in_imm = '0;
    logic        imem_we;
    logic [9:0]  imem_addr;
    logic [31:0] imem_wdata;
    logic        busy;
    logic        full;
    logic [10:0] count;
`ifdef INST_ENC_CHECK_EN
    logic        err;
`endif

    inst_encoder dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .stop       (stop),
        .base_addr  (base_addr),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_mnem    (in_mnem),
        .in_rs      (in_rs),
        .in_rt      (in_rt),
        .in_rd      (in_rd),
        .in_shamt   (in_shamt),
        .in_imm     (in_imm),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .busy       (busy),
        .full       (full),
        .count      (count)
`ifdef INST_ENC_CHECK_EN
        ,
        .err        (err)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [9:0]  addr;
        logic [31:0] word;
        logic [10:0] cnt;
        bit          consec;
    } exp_t;

    exp_t        sbq[$];
    int          n_vec  = 0;
    int          n_miss = 0;
    int          cyc    = 0;
    int          last_wr_cyc = -100;
    logic [9:0]  exp_addr = '0;
    logic [10:0] exp_cnt  = '0;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every write strobe must match the head of the scoreboard.
    initial begin
        forever begin
            exp_t e;
            @(negedge clk);
            if (imem_we === 1'b1) begin
                if (sbq.size() == 0) begin
                    n_vec++;
                    n_miss++;
                    $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, expected no write",
                             imem_addr, imem_wdata);
                end else begin
                    e = sbq.pop_front();
                    chk("wr_addr", 32'(imem_addr), 32'(e.addr));
                    chk("wr_data", imem_wdata, e.word);
                    chk("wr_count", 32'(count), 32'(e.cnt));
                    if (e.consec) chk("wr_back_to_back_gap", 32'(cyc - last_wr_cyc), 32'd1);
                end
                last_wr_cyc = cyc;
            end
        end
    end

    task automatic expect_wr(input logic [31:0] word, input bit consec);
        exp_t e;
        exp_cnt   = exp_cnt + 11'd1;
        e.addr    = exp_addr;
        e.word    = word;
        e.cnt     = exp_cnt;
        e.consec  = consec;
        sbq.push_back(e);
        exp_addr  = exp_addr + 10'd1;
    endtask

    task automatic send(input logic [4:0] m, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd, input logic [4:0] sh, input logic [25:0] imm);
        bit ok;
        ok       = 1'b0;
        in_mnem  = m;
        in_rs    = rs;
        in_rt    = rt;
        in_rd    = rd;
        in_shamt = sh;
        in_imm   = imm;
        in_valid = 1'b1;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            if (in_ready === 1'b1) ok = 1'b1;
        end
        if (!ok) begin
            n_vec++;
            n_miss++;
            $display("FAIL send_timeout: in_ready stayed 0, expected 1");
        end
        @(posedge clk);
        #1;
    endtask

    task automatic begin_prog(input logic [9:0] base);
        base_addr = base;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start     = 1'b0;
        exp_addr  = base;
        exp_cnt   = '0;
    endtask

    task automatic wait_idle();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 30 && !done; i++) begin
            @(negedge clk);
            if (busy === 1'b0) done = 1'b1;
        end
        chk("idle_reached_busy", 32'(busy), 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic end_prog();
        in_valid = 1'b0;
        stop     = 1'b1;
        @(posedge clk);
        #1;
        stop     = 1'b0;
        wait_idle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_imem_we", 32'(imem_we), 32'd0);
        chk("rst_imem_addr", 32'(imem_addr), 32'd0);
        chk("rst_imem_wdata", imem_wdata, 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single ADDI
        begin_prog(10'h010);
        @(negedge clk);
        chk("run_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        expect_wr(32'h2022_0005, 1'b0);
        send(MN_ADDI, 5'd1, 5'd2, 5'd0, 5'd0, 26'h0005);
        end_prog();
        chk("count_after_prog", 32'(count), 32'd1);

        // Back-to-back R-types including SYSCALL
        begin_prog(10'h010);
        expect_wr(32'h0022_1820, 1'b0);
        expect_wr(32'h0001_1100, 1'b1);
        expect_wr(32'h0000_000C, 1'b1);
        send(MN_ADD,     5'd1,  5'd2,  5'd3,  5'd0,  26'h0);
        send(MN_SLL,     5'd9,  5'd1,  5'd2,  5'd4,  26'h0);
        send(MN_SYSCALL, 5'd7,  5'd7,  5'd7,  5'd7,  26'h3FF_FFFF);
        end_prog();

        // J-type, store, and field-forcing cases
        begin_prog(10'h100);
        expect_wr(32'h0810_0000, 1'b0);
        expect_wr(32'hAFBF_FFFC, 1'b1);
        expect_wr(32'h1C60_0010, 1'b1);
        expect_wr(32'h03E0_0008, 1'b1);
        expect_wr(32'h0085_3004, 1'b1);
        expect_wr(32'h0001_17C3, 1'b1);
        send(MN_J,    5'd0,  5'd0,  5'd0, 5'd0,  26'h010_0000);
        send(MN_SW,   5'd29, 5'd31, 5'd0, 5'd0,  26'h000_FFFC);
        send(MN_BGTZ, 5'd3,  5'd7,  5'd0, 5'd0,  26'h000_0010);
        send(MN_JR,   5'd31, 5'd5,  5'd6, 5'd2,  26'h0);
        send(MN_SLLV, 5'd4,  5'd5,  5'd6, 5'd9,  26'h0);
        send(MN_SRA,  5'd7,  5'd1,  5'd2, 5'd31, 26'h0);
        end_prog();

        // Address-space exhaustion
        begin_prog(10'd1022);
        expect_wr(32'h2022_0005, 1'b0);
        expect_wr(32'h2064_0007, 1'b1);
        send(MN_ADDI, 5'd1, 5'd2, 5'd0, 5'd0, 26'h0005);
        send(MN_ADDI, 5'd3, 5'd4, 5'd0, 5'd0, 26'h0007);
        send(MN_ADDI, 5'd5, 5'd6, 5'd0, 5'd0, 26'h0009);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("full_flag", 32'(full), 32'd1);
        chk("full_busy", 32'(busy), 32'd1);
        chk("full_in_ready", 32'(in_ready), 32'd0);
        chk("full_count", 32'(count), 32'd2);
        chk("full_last_addr", 32'(imem_addr), 32'd1023);
        @(posedge clk);
        #1 stop = 1'b1;
        @(posedge clk);
        #1 stop = 1'b0;
        @(negedge clk);
        chk("full_stop_idle", 32'(busy), 32'd0);
        @(posedge clk);
        #1;

        // Illegal mnemonic between two ADDIs
        begin_prog(10'h020);
        expect_wr(32'h2022_0005, 1'b0);
`ifdef INST_ENC_CHECK_EN
        expect_wr(32'h2064_0007, 1'b0);
`else
        expect_wr(32'h0000_0000, 1'b1);
        expect_wr(32'h2064_0007, 1'b1);
`endif
        send(MN_ADDI, 5'd1, 5'd2, 5'd0, 5'd0, 26'h0005);
        send(5'd30,   5'd1, 5'd2, 5'd3, 5'd4, 26'h1234);
        send(MN_ADDI, 5'd3, 5'd4, 5'd0, 5'd0, 26'h0007);
        end_prog();
`ifdef INST_ENC_CHECK_EN
        chk("illegal_err", 32'(err), 32'd1);
        chk("illegal_count", 32'(count), 32'd2);
`else
        chk("illegal_count", 32'(count), 32'd3);
`endif

        // Reset with a request still pending
        begin_prog(10'h040);
        expect_wr(32'h2022_0005, 1'b0);
        expect_wr(32'h2401_FFFF, 1'b1);
        send(MN_ADDI,  5'd1, 5'd2, 5'd0, 5'd0, 26'h0005);
        send(MN_ADDIU, 5'd0, 5'd1, 5'd0, 5'd0, 26'h0FFFF);
        send(MN_ORI,   5'd2, 5'd3, 5'd0, 5'd0, 26'h000F0);
        in_valid = 1'b0;
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_imem_we", 32'(imem_we), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_count", 32'(count), 32'd0);
        chk("midrst_imem_addr", 32'(imem_addr), 32'd0);
        repeat (4) @(negedge clk);
        #1 rst_n = 1'b1;
        repeat (6) @(negedge clk);
        chk("post_rst_busy", 32'(busy), 32'd0);
        chk("post_rst_in_ready", 32'(in_ready), 32'd0);

        chk("scoreboard_drained", 32'(sbq.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

`default_nettype wire
